// File: rtl/shift_add_mult_if.sv
// Handshake and data bundle for shift_add_mult. The testbench drives the master side
// and the multiplier implements the slave side.
interface shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       m;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output start, signed_mode, m, q,
        input  busy, done, p
    );

    modport slave (
        input  start, signed_mode, m, q,
        output busy, done, p
    );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier. Signed operands are handled as sign-magnitude:
// the magnitudes are multiplied and the product is negated at the end, so latency never varies.
module shift_add_mult #(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    shift_add_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     m_mag_q, m_mag_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 eff_signed;
    logic                 m_neg, q_neg;
    logic [WIDTH-1:0]     m_abs, q_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   step_acc;

    assign eff_signed = SIGNED_EN && bus.signed_mode;
    assign m_neg      = eff_signed && bus.m[WIDTH-1];
    assign q_neg      = eff_signed && bus.q[WIDTH-1];
    // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign m_abs      = m_neg ? -bus.m : bus.m;
    assign q_abs      = q_neg ? -bus.q : bus.q;

    // Upper half accumulates; the lower half holds the multiplier being shifted out.
    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_mag_q} : '0);
    assign step_acc = {sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        p_d     = p_q;
        m_mag_d = m_mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_mag_d = m_abs;
                    acc_d   = {{WIDTH{1'b0}}, q_abs};
                    neg_d   = m_neg ^ q_neg;
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Negating a zero product yields zero, so no negative zero can appear.
                    p_d     = neg_q ? -step_acc : step_acc;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            p_q     <= '0;
            m_mag_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            m_mag_q <= m_mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench: directed vector table, randomized operands against an arithmetic
// reference, and hand-written sequences for start-while-busy, mid-run reset and back-to-back issue.
module tb_shift_add_mult;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   dones;
    int   dlat;
    logic [7:0] pcap;

    shift_add_mult_if #(.WIDTH(4)) a ();
    shift_add_mult_if #(.WIDTH(8)) b ();

    shift_add_mult #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(a));
    shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic       s;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: exact integer product of the operands as interpreted by the mode.
    function automatic logic [7:0] ref4(input logic [3:0] mv, input logic [3:0] qv, input logic sv);
        int x;
        int y;
        x = sv ? int'($signed(mv)) : int'(mv);
        y = sv ? int'($signed(qv)) : int'(qv);
        return 8'(x * y);
    endfunction

    // Caller is at a falling edge with the 4-bit DUT idle; returns at a falling edge, idle.
    task automatic op4(input logic [3:0] mv, input logic [3:0] qv, input logic sv,
                       input logic [7:0] exp, input string name);
        int l;
        a.start = 1'b1; a.m = mv; a.q = qv; a.signed_mode = sv;
        @(negedge clk);
        a.start = 1'b0; a.m = ~mv; a.q = ~qv; a.signed_mode = ~sv;
        check({name, " busy"}, 32'(a.busy), 32'd1);
        l = 0;
        while (a.done !== 1'b1 && l < 20) begin
            @(negedge clk);
            l++;
        end
        check({name, " latency"}, 32'(l), 32'd4);
        check({name, " p"}, 32'(a.p), 32'(exp));
        $display("op %s: m=%0d q=%0d signed=%0d p=0x%02h expected=0x%02h latency=%0d",
                 name, mv, qv, sv, a.p, exp, l);
        @(negedge clk);
        check({name, " done pulse"}, 32'(a.done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4'd15, 4'd15, 1'b0, 8'd225};
        vecs[1] = '{4'd6,  4'd15, 1'b0, 8'd90};
        vecs[2] = '{4'd0,  4'd6,  1'b0, 8'd0};
        vecs[3] = '{4'h8,  4'h8,  1'b1, 8'd64};
        vecs[4] = '{4'h8,  4'd7,  1'b1, 8'hC8};
        vecs[5] = '{4'hF,  4'd1,  1'b1, 8'hFF};
        vecs[6] = '{4'd0,  4'h9,  1'b1, 8'd0};
        vecs[7] = '{4'd7,  4'h9,  1'b1, 8'hCF};
        vecs[8] = '{4'hF,  4'hF,  1'b1, 8'd1};

        a.start = 1'b1; a.m = 4'd3; a.q = 4'd3; a.signed_mode = 1'b0;
        b.start = 1'b0; b.m = '0; b.q = '0; b.signed_mode = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(a.busy), 32'd0);
        check("reset done", 32'(a.done), 32'd0);
        check("reset p", 32'(a.p), 32'd0);
        check("reset p w8", 32'(b.p), 32'd0);

        rst = 1'b0;
        op4(4'd3, 4'd5, 1'b0, 8'd15, "first after reset");

        for (int i = 0; i < 9; i++)
            op4(vecs[i].m, vecs[i].q, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [3:0] mv;
            logic [3:0] qv;
            logic       sv;
            mv = 4'($urandom);
            qv = 4'($urandom);
            sv = 1'($urandom);
            op4(mv, qv, sv, ref4(mv, qv, sv), $sformatf("rand%0d", i));
        end

        // Unsigned-only 8-bit instance ignores signed_mode.
        b.start = 1'b1; b.m = 8'd255; b.q = 8'd255; b.signed_mode = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        lat = 0;
        while (b.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("w8 latency", 32'(lat), 32'd8);
        check("w8 p", 32'(b.p), 32'd65025);
        $display("op w8: m=255 q=255 signed=1 p=%0d latency=%0d", b.p, lat);
        @(negedge clk);

        // start held in every CALC and DONE cycle with changing operands.
        a.start = 1'b1; a.m = 4'd3; a.q = 4'd5; a.signed_mode = 1'b0;
        @(negedge clk);
        dones = 0; dlat = -1; pcap = '0;
        for (int i = 0; i < 14; i++) begin
            if (a.done === 1'b1) begin
                dones++;
                pcap = a.p;
                dlat = i;
            end
            a.start = (i < 5);
            a.m = 4'($urandom); a.q = 4'($urandom); a.signed_mode = 1'($urandom);
            @(negedge clk);
        end
        check("busy start dones", 32'(dones), 32'd1);
        check("busy start p", 32'(pcap), 32'd15);
        check("busy start latency", 32'(dlat), 32'(4));
        $display("op busy-start: dones=%0d p=%0d latency=%0d", dones, pcap, dlat);

        // Reset on the second CALC step aborts the operation.
        a.start = 1'b1; a.m = 4'd7; a.q = 4'd7; a.signed_mode = 1'b0;
        @(negedge clk);
        a.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(a.busy), 32'd0);
        check("abort p", 32'(a.p), 32'd0);
        check("abort done", 32'(a.done), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (a.done === 1'b1) dones++;
            @(negedge clk);
        end
        check("abort no done", 32'(dones), 32'd0);
        $display("op abort: busy=%0d p=%0d later_dones=%0d", a.busy, a.p, dones);
        op4(4'd7, 4'd7, 1'b0, 8'd49, "after abort");

        // Back-to-back with start held high: results every WIDTH+2 cycles.
        a.start = 1'b1; a.m = 4'd5; a.q = 4'd10; a.signed_mode = 1'b0;
        @(negedge clk);
        a.m = 4'd7; a.q = 4'd8;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (a.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    check("b2b first latency", 32'(i), 32'd4);
                    check("b2b first p", 32'(a.p), 32'd50);
                end else if (dones == 2) begin
                    check("b2b second latency", 32'(i), 32'd10);
                    check("b2b second p", 32'(a.p), 32'd56);
                end
                $display("op b2b: done #%0d at cycle %0d p=%0d", dones, i, a.p);
            end
            if (i == 6) a.start = 1'b0;
            @(negedge clk);
        end
        check("b2b dones", 32'(dones), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
